fir_l2_serializer: RTL and testbench

FIR_L2_SERIALIZER -- requirements
Module: fir_l2_serializer

---
 rtl/fir_pkg.sv | 18 +
 rtl/fir_pair_fifo.sv | 66 ++++++
 rtl/fir_l2_serializer.sv | 89 ++++++++
 tb/tb_fir_l2_serializer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fir_pkg
// Description : Shared constants and phase type for the L=2 FIR datapath.
// Revision    : 1.0  initial release
// ============================================================================
package fir_pkg;

    localparam int DATA_W = 24;
    localparam int L      = 2;

    typedef enum logic {
        PH_EVEN = 1'b0,
        PH_ODD  = 1'b1
    } phase_t;

endpackage
`default_nettype wire

// File: rtl/fir_pair_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fir_pair_fifo
// Description : Circular buffer of even/odd sample pairs with occupancy level.
// Revision    : 1.0  initial release
// ============================================================================
module fir_pair_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int          AW     = $clog2(DEPTH);
    localparam logic [AW:0] c_full = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_wr;
    logic             w_rd;

    assign w_wr    = wr_en && (r_level != c_full);
    assign w_rd    = rd_en && (r_level != '0);
    assign rd_data = r_mem[r_rd_ptr];
    assign level   = r_level;

    // Pointers are exactly AW bits wide, so wrap modulo DEPTH is implicit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_l2_serializer.sv
`default_nettype none
// ============================================================================
// Module      : fir_l2_serializer
// Description : Buffers even/odd sample pairs and emits them as one serial
//               sample stream, even sample first.
// Revision    : 1.0  initial release
// ============================================================================
module fir_l2_serializer
    import fir_pkg::*;
#(
    parameter int DATA_W = fir_pkg::DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [DATA_W-1:0]    in_data1,
    input  logic signed [DATA_W-1:0]    in_data2,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [DATA_W-1:0]    out_data,
    output logic                        out_phase,
    output logic [$clog2(DEPTH):0]      level
);

    localparam int          AW     = $clog2(DEPTH);
    localparam int          PAIR_W = L * DATA_W;
    localparam logic [AW:0] c_full = (AW+1)'(DEPTH);

    phase_t                   r_phase;
    logic signed [DATA_W-1:0] r_last;
    logic signed [DATA_W-1:0] w_sample;
    logic [PAIR_W-1:0]        w_head;
    logic [AW:0]              w_level;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_retire;

    // Handshake flags come only from registered occupancy, never from out_ready.
    assign in_ready  = (w_level < c_full);
    assign out_valid = (w_level != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_retire  = w_pop && (r_phase == PH_ODD);

    assign w_sample  = (r_phase == PH_ODD) ? $signed(w_head[2*DATA_W-1:DATA_W])
                                           : $signed(w_head[DATA_W-1:0]);
    assign out_data  = out_valid ? w_sample : r_last;
    assign out_phase = r_phase;
    assign level     = w_level;

    fir_pair_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .wr_en   (w_push),
        .wr_data ({in_data2, in_data1}),
        .rd_en   (w_retire),
        .rd_data (w_head),
        .level   (w_level)
    );

    // r_last captures each presented sample so the bus holds it once empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase <= PH_EVEN;
            r_last  <= '0;
        end else begin
            if (out_valid) begin
                r_last <= w_sample;
            end
            if (flush) begin
                r_phase <= PH_EVEN;
            end else if (w_pop) begin
                case (r_phase)
                    PH_EVEN: r_phase <= PH_ODD;
                    default: r_phase <= PH_EVEN;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_l2_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_l2_serializer
// Description : Self-checking bench for fir_l2_serializer against a sample-queue model.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fir_l2_serializer;

    localparam int DW    = 24;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic                 clk       = 1'b0;
    logic                 reset     = 1'b0;
    logic                 flush     = 1'b0;
    logic                 in_valid  = 1'b0;
    logic                 out_ready = 1'b0;
    logic signed [DW-1:0] in_data1  = '0;
    logic signed [DW-1:0] in_data2  = '0;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_phase;
    logic signed [DW-1:0] out_data;
    logic [LW-1:0]        level;

    int n_vec  = 0;
    int n_err  = 0;
    bit done   = 1'b0;
    int q[$];
    int last_v = 0;

    fir_l2_serializer #(
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_phase (out_phase),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a flat queue of serial samples; the head is what must be shown.
    always @(posedge clk or negedge reset) begin
        bit push;
        bit pop;
        if (!reset) begin
            q.delete();
            last_v = 0;
        end else begin
            push = in_valid && (((q.size() + 1) / 2) < DEPTH);
            pop  = (q.size() != 0) && out_ready;
            if (q.size() != 0) last_v = q[0];
            if (flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (push) begin
                    q.push_back(int'(in_data1));
                    q.push_back(int'(in_data2));
                end
            end
        end
    end

    always @(negedge clk) begin
        int exp_lvl;
        if (!done) begin
            exp_lvl = (q.size() + 1) / 2;
            check("level",       int'(level),     exp_lvl);
            check("level_bound", int'(int'(level) <= DEPTH), 1);
            check("in_ready",    int'(in_ready),  int'(exp_lvl < DEPTH));
            check("out_valid",   int'(out_valid), int'(q.size() != 0));
            check("out_phase",   int'(out_phase), q.size() % 2);
            check("out_data",    int'(out_data),  (q.size() != 0) ? q[0] : last_v);
        end
    end

    task automatic push_pair(input int a, input int b);
        in_valid = 1'b1;
        in_data1 = DW'(a);
        in_data2 = DW'(b);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_data",  int'(out_data),  0);
        check("rst_in_ready",  int'(in_ready),  1);
        check("rst_out_valid", int'(out_valid), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Single pair, immediate drain
        out_ready = 1'b1;
        push_pair(100, -200);
        check("p1_even_data",  int'(out_data),  100);
        check("p1_even_phase", int'(out_phase), 0);
        @(negedge clk);
        check("p1_odd_data",   int'(out_data),  -200);
        check("p1_odd_phase",  int'(out_phase), 1);
        @(negedge clk);
        check("p1_empty_valid", int'(out_valid), 0);
        check("p1_hold_data",   int'(out_data),  -200);

        // Fill to full, refuse a fifth pair, then drain in order
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) push_pair(2*k - 1, 2*k);
        check("full_level",    int'(level),    4);
        check("full_in_ready", int'(in_ready), 0);
        push_pair(9, 10);
        check("full_refused_level", int'(level), 4);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("drain_order", int'(out_data), i);
            @(negedge clk);
        end
        check("drain_empty", int'(out_valid), 0);

        // One pair every two cycles streams with no bubble
        for (int k = 0; k < 6; k++) begin
            push_pair(int'($urandom_range(0, 1000)), -int'($urandom_range(0, 1000)));
            check("stream_valid_a", int'(out_valid), 1);
            check("stream_level",   int'(int'(level) <= 1), 1);
            @(negedge clk);
            check("stream_valid_b", int'(out_valid), 1);
        end
        @(negedge clk);

        // Back-pressure holds the presented sample
        out_ready = 1'b0;
        push_pair(5, 6);
        repeat (3) begin
            check("stall_data",  int'(out_data),  5);
            check("stall_phase", int'(out_phase), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Flush mid-pair, overriding a simultaneous push and pop
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) push_pair(30 + k, 40 + k);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("pre_flush_phase", int'(out_phase), 1);
        check("pre_flush_level", int'(level),     3);
        flush = 1'b1; out_ready = 1'b1;
        push_pair(77, 78);
        flush = 1'b0;
        check("flush_level", int'(level),     0);
        check("flush_phase", int'(out_phase), 0);
        push_pair(9, 10);
        check("post_flush_first", int'(out_data), 9);
        @(negedge clk);
        check("post_flush_second", int'(out_data), 10);
        @(negedge clk);

        // Asynchronous reset mid-pair
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) push_pair(50 + k, 60 + k);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("pre_rst_phase", int'(out_phase), 1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_level", int'(level),     0);
        check("async_rst_phase", int'(out_phase), 0);
        @(negedge clk);
        reset = 1'b1; out_ready = 1'b1;
        push_pair(9, 10);
        check("post_rst_first", int'(out_data), 9);
        @(negedge clk);
        check("post_rst_second", int'(out_data), 10);
        @(negedge clk);

        // Randomised traffic with varying back-pressure
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data1  = DW'($urandom);
            in_data2  = DW'($urandom);
            if (c < 5000) out_ready = ($urandom_range(0, 3) == 0);
            else          out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        done     = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
